// File: rtl/spec_free_list_pkg.sv
// Shared sizing constants for the speculative physical-register free list
// and its release compactor.
package spec_free_list_pkg;
  localparam int SIZE_PHYSICAL_TABLE = 96;
  localparam int SIZE_PHYSICAL_LOG   = 7;
  localparam int SIZE_RMT            = 32;
  localparam int SIZE_RMT_LOG        = 5;
  localparam int SIZE_FREE_LIST      = SIZE_PHYSICAL_TABLE - SIZE_RMT;
  localparam int SIZE_FREE_LIST_LOG  = 6;
  localparam int COMMIT_WIDTH        = 4;
endpackage

// File: rtl/spec_free_list_release_compactor.sv
// Packs up to four committed release slots into consecutive write ports,
// preserving slot order, and reports how many were valid.
module spec_free_list_release_compactor
  import spec_free_list_pkg::*;
(
  input  logic [COMMIT_WIDTH-1:0]                   valid_i,
  input  logic [COMMIT_WIDTH*SIZE_PHYSICAL_LOG-1:0] data_i,
  output logic [COMMIT_WIDTH-1:0]                   wr_en_o,
  output logic [COMMIT_WIDTH*SIZE_PHYSICAL_LOG-1:0] wr_data_o,
  output logic [2:0]                                n_rel_o
);

  always_comb begin
    logic [2:0] prefix;
    wr_en_o   = '0;
    wr_data_o = '0;
    prefix    = '0;
    // prefix counts the valid slots below s, i.e. the write port slot s lands on
    for (int s = 0; s < COMMIT_WIDTH; s++) begin
      if (valid_i[s]) begin
        wr_en_o[prefix[1:0]] = 1'b1;
        wr_data_o[prefix[1:0]*SIZE_PHYSICAL_LOG +: SIZE_PHYSICAL_LOG] =
          data_i[s*SIZE_PHYSICAL_LOG +: SIZE_PHYSICAL_LOG];
        prefix = prefix + 3'd1;
      end
    end
    n_rel_o = prefix;
  end

endmodule

// File: rtl/spec_free_list.sv
// Speculative free list: circular buffer of free physical registers feeding
// rename four at a time, refilled by commit, fully restored on recovery.
module spec_free_list
  import spec_free_list_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          reqFreeList_i,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg0_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg1_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg2_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg3_o,
  output logic                          freeListEmpty_o,
  input  logic                          releasedValid0_i,
  input  logic                          releasedValid1_i,
  input  logic                          releasedValid2_i,
  input  logic                          releasedValid3_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap0_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap1_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap2_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap3_i,
  input  logic                          recoverFlag_i,
  output logic [SIZE_FREE_LIST_LOG:0]   freeCnt_o,
  output logic                          overflow_o
);

  localparam int PW = SIZE_PHYSICAL_LOG;
  localparam int CW = SIZE_FREE_LIST_LOG + 1;

  logic [PW-1:0]                 entry_q [SIZE_FREE_LIST];
  logic [SIZE_FREE_LIST_LOG-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          overflow_q, overflow_d;

  logic [COMMIT_WIDTH-1:0]    wr_en;
  logic [COMMIT_WIDTH*PW-1:0] wr_data;
  logic [2:0]                 n_rel;
  logic                       empty;
  logic                       pop;
  logic [CW:0]                cnt_sum;

  spec_free_list_release_compactor u_compactor (
    .valid_i   ({releasedValid3_i, releasedValid2_i, releasedValid1_i, releasedValid0_i}),
    .data_i    ({releasedPhyMap3_i, releasedPhyMap2_i, releasedPhyMap1_i, releasedPhyMap0_i}),
    .wr_en_o   (wr_en),
    .wr_data_o (wr_data),
    .n_rel_o   (n_rel)
  );

  // Rename handshake: reqFreeList_i is the request, !freeListEmpty_o the grant;
  // a group of four is consumed only on a cycle where both hold and no recovery.
  assign empty = (cnt_q < CW'(COMMIT_WIDTH));
  assign pop   = reqFreeList_i && !empty && !recoverFlag_i;

  // One extra bit so an over-release is visible before it reaches the count.
  assign cnt_sum = {1'b0, cnt_q} + (CW+1)'(n_rel) - (pop ? (CW+1)'(COMMIT_WIDTH) : '0);

  always_comb begin
    tail_d     = tail_q + SIZE_FREE_LIST_LOG'(n_rel);
    head_d     = pop ? head_q + SIZE_FREE_LIST_LOG'(COMMIT_WIDTH) : head_q;
    cnt_d      = cnt_sum[CW-1:0];
    overflow_d = overflow_q | (cnt_sum > (CW+1)'(SIZE_FREE_LIST));
    // Squashed allocations sit between committed tail and head, so rewinding
    // head onto the tail returns every one of them to the free set.
    if (recoverFlag_i) begin
      head_d = tail_d;
      cnt_d  = CW'(SIZE_FREE_LIST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= CW'(SIZE_FREE_LIST);
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SIZE_FREE_LIST; i++) begin
        entry_q[i] <= PW'(SIZE_RMT + i);
      end
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (wr_en[k]) begin
          entry_q[tail_q + SIZE_FREE_LIST_LOG'(k)] <= wr_data[k*PW +: PW];
        end
      end
    end
  end

  assign freeReg0_o      = entry_q[head_q];
  assign freeReg1_o      = entry_q[head_q + SIZE_FREE_LIST_LOG'(1)];
  assign freeReg2_o      = entry_q[head_q + SIZE_FREE_LIST_LOG'(2)];
  assign freeReg3_o      = entry_q[head_q + SIZE_FREE_LIST_LOG'(3)];
  assign freeListEmpty_o = empty;
  assign freeCnt_o       = cnt_q;
  assign overflow_o      = overflow_q;

endmodule
